// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned requests to instruction memory,
// holds one fetched instruction for decode, and follows execute-stage redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch,
    input  logic        zero_flag,
    input  logic [31:0] pc_branch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        inst_ready
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]  state_reg;
    logic        armed_reg;
    logic [31:0] next_pc_reg;
    logic [31:0] imem_addr_reg;
    logic        imem_req_reg;
    logic        inst_valid_reg;
    logic [31:0] inst_reg;
    logic [31:0] pc_reg;

    logic        redirect;
    logic [31:0] target_aligned;
    logic [31:0] seq_pc;

    assign redirect       = branch & zero_flag;
    assign target_aligned = {pc_branch[31:2], 2'b00};
    assign seq_pc         = pc_reg + 32'(PC_STEP);

    // Every transition that starts a new request loads imem_addr and imem_req
    // directly, so the request is visible the cycle after the decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            armed_reg      <= 1'b0;
            next_pc_reg    <= RESET_PC;
            imem_addr_reg  <= RESET_PC;
            imem_req_reg   <= 1'b0;
            inst_valid_reg <= 1'b0;
            inst_reg       <= 32'h0000_0000;
            pc_reg         <= RESET_PC;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // One settle cycle after reset release before the first request.
                    armed_reg <= 1'b1;
                    if (armed_reg) begin
                        state_reg     <= ST_FETCH;
                        imem_req_reg  <= 1'b1;
                        imem_addr_reg <= next_pc_reg;
                    end
                end

                ST_FETCH: begin
                    if (imem_ack && redirect) begin
                        next_pc_reg   <= target_aligned;
                        imem_addr_reg <= target_aligned;
                    end else if (imem_ack) begin
                        inst_reg       <= imem_rdata;
                        pc_reg         <= imem_addr_reg;
                        imem_req_reg   <= 1'b0;
                        inst_valid_reg <= 1'b1;
                        state_reg      <= ST_HOLD;
                    end else if (redirect) begin
                        next_pc_reg <= target_aligned;
                        state_reg   <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    // The outstanding request keeps its address until acked; its data is stale.
                    if (imem_ack) begin
                        if (redirect) begin
                            next_pc_reg   <= target_aligned;
                            imem_addr_reg <= target_aligned;
                        end else begin
                            imem_addr_reg <= next_pc_reg;
                        end
                        state_reg <= ST_FETCH;
                    end else if (redirect) begin
                        next_pc_reg <= target_aligned;
                    end
                end

                ST_HOLD: begin
                    if (redirect) begin
                        next_pc_reg    <= target_aligned;
                        imem_addr_reg  <= target_aligned;
                        imem_req_reg   <= 1'b1;
                        inst_valid_reg <= 1'b0;
                        state_reg      <= ST_FETCH;
                    end else if (inst_ready) begin
                        next_pc_reg    <= seq_pc;
                        imem_addr_reg  <= seq_pc;
                        imem_req_reg   <= 1'b1;
                        inst_valid_reg <= 1'b0;
                        state_reg      <= ST_FETCH;
                    end
                end

                default: begin
                    state_reg      <= ST_IDLE;
                    imem_req_reg   <= 1'b0;
                    inst_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = imem_req_reg;
    assign imem_addr  = imem_addr_reg;
    assign inst_valid = inst_valid_reg;
    assign inst       = inst_reg;
    assign pc         = pc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] STEP   = 32'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch, zero_flag, imem_ack, inst_ready;
    logic [31:0] pc_branch, imem_rdata;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst, pc;

    int checks = 0;
    int errors = 0;

    // Model: an outstanding request (possibly stale), a held instruction,
    // and the address the next request will use.
    int          m_boot;
    logic        m_out, m_stale, m_hold;
    logic [31:0] m_addr, m_target, m_inst, m_pc;
    int          wait_cnt = 0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .branch(branch), .zero_flag(zero_flag),
        .pc_branch(pc_branch), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
        .inst(inst), .pc(pc), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_boot = 2; m_out = 1'b0; m_stale = 1'b0; m_hold = 1'b0;
        m_addr = RST_PC; m_target = RST_PC; m_inst = 32'h0; m_pc = RST_PC;
    endtask

    task automatic model_step(input logic b, input logic z, input logic [31:0] tgt,
                              input logic ack, input logic [31:0] rd, input logic rdy,
                              output logic issued);
        logic        redir;
        logic [31:0] t;
        redir  = b & z;
        t      = tgt & 32'hFFFF_FFFC;
        issued = 1'b0;
        if (m_boot > 0) begin
            m_boot--;
            if (m_boot == 0) begin m_out = 1'b1; m_addr = m_target; issued = 1'b1; end
        end else if (m_out) begin
            if (ack) begin
                if (redir) m_target = t;
                if (m_stale || redir) begin
                    m_stale = 1'b0; m_addr = m_target; issued = 1'b1;
                end else begin
                    m_out = 1'b0; m_hold = 1'b1; m_inst = rd; m_pc = m_addr;
                end
            end else if (redir) begin
                m_target = t; m_stale = 1'b1;
            end
        end else if (m_hold) begin
            if (redir) m_target = t;
            else if (rdy) m_target = m_pc + STEP;
            if (redir || rdy) begin
                m_hold = 1'b0; m_out = 1'b1; m_addr = m_target; issued = 1'b1;
            end
        end
    endtask

    task automatic compare();
        checks++;
        if (imem_req !== m_out || imem_addr !== m_addr || inst_valid !== m_hold ||
            inst !== m_inst || pc !== m_pc) begin
            errors++;
            $display("FAIL cmp t=%0t got req=%b addr=%h valid=%b inst=%h pc=%h need req=%b addr=%h valid=%b inst=%h pc=%h",
                     $time, imem_req, imem_addr, inst_valid, inst, pc,
                     m_out, m_addr, m_hold, m_inst, m_pc);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h need=%h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic tick(input logic b, input logic z, input logic [31:0] tgt,
                        input logic ack, input logic [31:0] rd, input logic rdy);
        logic issued;
        branch = b; zero_flag = z; pc_branch = tgt;
        imem_ack = ack; imem_rdata = rd; inst_ready = rdy;
        model_step(b, z, tgt, ack, rd, rdy, issued);
        if (issued) wait_cnt = $urandom_range(0, 3);
        @(negedge clk);
        compare();
    endtask

    task automatic idle_tick();
        tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // Request at a is visible; ack two cycles later with data d, then check the hold.
    task automatic fetch_one(input logic [31:0] a, input logic [31:0] d);
        chk("req_on", {31'h0, imem_req}, 32'h1);
        chk("req_addr", imem_addr, a);
        idle_tick();
        idle_tick();
        tick(1'b0, 1'b0, 32'h0, 1'b1, d, 1'b0);
        chk("valid", {31'h0, inst_valid}, 32'h1);
        chk("inst", inst, d);
        chk("pc", pc, a);
        chk("req_off", {31'h0, imem_req}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; branch = 1'b0; zero_flag = 1'b0; pc_branch = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        compare();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);

        idle_tick();
        chk("edge1_req", {31'h0, imem_req}, 32'h0);
        idle_tick();

        // Sequential fetch 0x0, 0x4, 0x8 with decode accepting.
        for (int k = 0; k < 3; k++) begin
            fetch_one(32'(k * 4), 32'h1000_0000 + 32'(k));
            tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        end

        // Decode stalls for 5 cycles; stray acks in HOLD are ignored.
        fetch_one(32'hC, 32'hCAFE_000C);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b0, 32'h0, k[0], 32'hBAD0_0000, 1'b0);
            chk("stall_valid", {31'h0, inst_valid}, 32'h1);
            chk("stall_inst", inst, 32'hCAFE_000C);
            chk("stall_pc", pc, 32'hC);
            chk("stall_req", {31'h0, imem_req}, 32'h0);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Redirect from HOLD wins over inst_ready.
        fetch_one(32'h10, 32'h0000_0010);
        tick(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
        chk("redir_hold", imem_addr, 32'h100);
        fetch_one(32'h100, 32'h0000_0100);
        tick(1'b1, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0);

        // Redirect while 0x20 is outstanding; its data must be dropped.
        tick(1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        chk("drain_addr", imem_addr, 32'h20);
        chk("drain_req", {31'h0, imem_req}, 32'h1);
        idle_tick();
        idle_tick();
        tick(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_0020, 1'b0);
        chk("drain_valid", {31'h0, inst_valid}, 32'h0);
        chk("drain_next", imem_addr, 32'h200);

        // Ack and redirect together, then wrap at the top of memory.
        tick(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hDEAD_0200, 1'b0);
        chk("ackredir_addr", imem_addr, 32'hFFFF_FFFC);
        chk("ackredir_valid", {31'h0, inst_valid}, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1'b1, 32'h7777_7777, 1'b0);
        chk("top_pc", pc, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("wrap_addr", imem_addr, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_0000, 1'b0);
        tick(1'b1, 1'b1, 32'h103, 1'b0, 32'h0, 1'b0);
        chk("align_addr", imem_addr, 32'h100);

        // Reset in the middle of a drain.
        tick(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", {31'h0, imem_req}, 32'h0);
        chk("arst_valid", {31'h0, inst_valid}, 32'h0);
        chk("arst_addr", imem_addr, RST_PC);
        chk("arst_pc", pc, RST_PC);
        chk("arst_inst", inst, 32'h0);
        model_reset();
        branch = 1'b0; zero_flag = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare();
        tick(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("late_ack_req", {31'h0, imem_req}, 32'h0);
        idle_tick();
        chk("restart_addr", imem_addr, RST_PC);
        chk("restart_req", {31'h0, imem_req}, 32'h1);

        // Randomized traffic with a memory that acks after 0..3 cycles.
        for (int i = 0; i < 3000; i++) begin
            logic        b, z, a, r;
            logic [31:0] t;
            b = ($urandom_range(0, 5) == 0);
            z = ($urandom_range(0, 2) != 0);
            t = $urandom;
            if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8 | ($urandom & 32'h7);
            r = ($urandom_range(0, 1) == 1);
            if (m_out) begin
                a = (wait_cnt == 0);
                if (!a) wait_cnt--;
            end else begin
                a = ($urandom_range(0, 9) == 0);
            end
            tick(b, z, t, a, $urandom, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
